// File: rtl/vector_pkg.sv
// ---------------------------------------------------------------------------
// vector_pkg
// Shared definitions for the vector result serializer: the length-field
// width, the serializer state encoding and the bytes-per-element helper.
// ---------------------------------------------------------------------------
package vector_pkg;

    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } ser_state_t;

    // Number of whole bytes needed to carry one element of 'bits' bits.
    function automatic int bytes_per_elem(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/vector_byte_select.sv
// ---------------------------------------------------------------------------
// vector_byte_select
// Purely combinational byte picker: returns byte i_byte_idx (little-endian)
// of element i_elem_idx of the snapshot. Bits above BITS in the top byte
// read as zero.
//
// Ports:
//   i_elems     snapshot vector, N elements of BITS bits
//   i_elem_idx  element to read
//   i_byte_idx  byte within that element, 0 = least significant
//   o_byte      selected byte
// ---------------------------------------------------------------------------
module vector_byte_select
    import vector_pkg::*;
#(
    parameter int BITS = 8,
    parameter int N    = 4,
    localparam int BPE = bytes_per_elem(BITS),
    localparam int EW  = (N > 1) ? $clog2(N) : 1,
    localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1
) (
    input  logic [BITS-1:0] i_elems [N-1:0],
    input  logic [EW-1:0]   i_elem_idx,
    input  logic [BW-1:0]   i_byte_idx,
    output logic [7:0]      o_byte
);

    logic [8*BPE-1:0] w_padded;

    always_comb begin
        w_padded            = '0;
        w_padded[BITS-1:0]  = i_elems[i_elem_idx];
        o_byte              = w_padded[8*i_byte_idx +: 8];
    end

endmodule

// File: rtl/vector_result_serializer.sv
// ---------------------------------------------------------------------------
// vector_result_serializer
// Snapshots the ALU result vector on a capture strobe and streams it over a
// valid/ready byte interface: one length byte (clipped to N), then every
// element least-significant byte first, element 0 first. All outputs are
// registered; done pulses for one cycle after the last byte is accepted.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous reset, active-low
//   S         ALU result vector (N x BITS)
//   S_len     ALU result length
//   capture   start a transfer (only honoured while idle)
//   busy      transfer in progress
//   tx_data   outgoing byte
//   tx_valid  tx_data valid
//   tx_ready  downstream accepts the byte
//   done      one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module vector_result_serializer
    import vector_pkg::*;
#(
    parameter int BITS = 8,
    parameter int N    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BITS-1:0]  S [N-1:0],
    input  logic [LEN_W-1:0] S_len,
    input  logic             capture,
    output logic             busy,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             done
);

    localparam int BPE = bytes_per_elem(BITS);
    localparam int EW  = (N > 1) ? $clog2(N) : 1;
    localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1;

    ser_state_t       r_state, w_state_nx;
    logic [BITS-1:0]  r_snap [N-1:0];
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_eff_len;
    logic [EW-1:0]    r_e, w_e_nx;
    logic [BW-1:0]    r_b, w_b_nx;
    logic             r_busy, w_busy_nx;
    logic             r_valid, w_valid_nx;
    logic             r_done, w_done_nx;
    logic [7:0]       r_data, w_data_nx;
    logic [7:0]       w_sel;
    logic             w_load;
    logic             w_hs;
    logic             w_last_byte;
    logic             w_last_elem;

    assign w_eff_len   = (S_len > LEN_W'(N)) ? LEN_W'(N) : S_len;
    assign w_hs        = r_valid & tx_ready;
    assign w_last_byte = (r_b == BW'(BPE - 1));
    assign w_last_elem = (LEN_W'(r_e) == (r_len - LEN_W'(1)));

    // Next-state, counters and control outputs.
    always_comb begin
        w_state_nx = r_state;
        w_e_nx     = r_e;
        w_b_nx     = r_b;
        w_busy_nx  = r_busy;
        w_valid_nx = r_valid;
        w_done_nx  = 1'b0;
        w_load     = 1'b0;

        case (r_state)
            IDLE: begin
                if (capture) begin
                    w_load     = 1'b1;
                    w_state_nx = HEADER;
                    w_busy_nx  = 1'b1;
                    w_valid_nx = 1'b1;
                end
            end
            HEADER: begin
                if (w_hs) begin
                    if (r_len == '0) begin
                        w_state_nx = IDLE;
                        w_busy_nx  = 1'b0;
                        w_valid_nx = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = DATA;
                        w_e_nx     = '0;
                        w_b_nx     = '0;
                    end
                end
            end
            DATA: begin
                if (w_hs) begin
                    if (!w_last_byte) begin
                        w_b_nx = r_b + BW'(1);
                    end else if (!w_last_elem) begin
                        w_b_nx = '0;
                        w_e_nx = r_e + EW'(1);
                    end else begin
                        w_state_nx = IDLE;
                        w_busy_nx  = 1'b0;
                        w_valid_nx = 1'b0;
                        w_done_nx  = 1'b1;
                        w_e_nx     = '0;
                        w_b_nx     = '0;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    // The mux looks at the *next* indices so the byte is ready in the
    // register the same cycle the counters advance.
    vector_byte_select #(
        .BITS (BITS),
        .N    (N)
    ) u_byte_select (
        .i_elems    (r_snap),
        .i_elem_idx (w_e_nx),
        .i_byte_idx (w_b_nx),
        .o_byte     (w_sel)
    );

    // Outgoing byte: header on capture, new element byte after each data
    // handshake, cleared when the link goes idle, held otherwise (stall).
    always_comb begin
        w_data_nx = r_data;
        if (w_load) begin
            w_data_nx = w_eff_len;
        end else if (w_hs && (w_state_nx == DATA)) begin
            w_data_nx = w_sel;
        end else if (!w_valid_nx) begin
            w_data_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_e     <= '0;
            r_b     <= '0;
            r_len   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_e     <= w_e_nx;
            r_b     <= w_b_nx;
            r_busy  <= w_busy_nx;
            r_valid <= w_valid_nx;
            r_done  <= w_done_nx;
            r_data  <= w_data_nx;
            if (w_load) begin
                r_len <= w_eff_len;
            end
        end
    end

    // Snapshot is pure data; it is only meaningful after a capture.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_snap <= S;
        end
    end

    assign busy     = r_busy;
    assign tx_valid = r_valid;
    assign tx_data  = r_data;
    assign done     = r_done;

endmodule

// File: tb/tb_vector_result_serializer.sv
module tb_vector_result_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 8-bit instance
    logic [7:0]  a_S [3:0];
    logic [7:0]  a_len = 8'd0;
    logic        a_cap = 1'b0;
    logic        a_busy, a_valid, a_done;
    logic [7:0]  a_data;
    logic        a_ready = 1'b1;

    // 12-bit instance
    logic [11:0] b_S [3:0];
    logic [7:0]  b_len = 8'd0;
    logic        b_cap = 1'b0;
    logic        b_busy, b_valid, b_done;
    logic [7:0]  b_data;
    logic        b_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [8];
    logic       pat_q [16];

    always #5 clk = ~clk;

    vector_result_serializer #(.BITS(8), .N(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .S(a_S), .S_len(a_len), .capture(a_cap),
        .busy(a_busy), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .done(a_done)
    );

    vector_result_serializer #(.BITS(12), .N(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .S(b_S), .S_len(b_len), .capture(b_cap),
        .busy(b_busy), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .done(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic capture_a(input logic [7:0] len);
        a_len = len;
        a_cap = 1'b1;
        tick();
        a_cap = 1'b0;
    endtask

    // Drives tx_ready from pat_q (then 1), collects accepted bytes against
    // exp_q, checks stall stability and a single trailing done pulse.
    task automatic run_a(input int n, input int plen, input bit chk_cycles);
        int         idx = 0;
        int         c = 0;
        int         dones = 0;
        logic       stall = 1'b0;
        logic [7:0] hold = 8'h00;
        while (c < 200 && dones == 0) begin
            a_ready = (c < plen) ? pat_q[c] : 1'b1;
            if (stall) begin
                check("stall_valid", {31'd0, a_valid}, 32'd1);
                check("stall_data", {24'd0, a_data}, {24'd0, hold});
            end
            if (a_valid) check("busy_during", {31'd0, a_busy}, 32'd1);
            if (a_valid && a_ready) begin
                check("byte", {24'd0, a_data}, {24'd0, exp_q[idx & 7]});
                idx++;
                stall = 1'b0;
            end else begin
                stall = a_valid;
            end
            hold = a_data;
            tick();
            c++;
            if (a_done) begin
                dones++;
                check("done_no_valid", {31'd0, a_valid}, 32'd0);
                check("done_no_busy", {31'd0, a_busy}, 32'd0);
            end
        end
        check("beat_count", idx, n);
        check("done_seen", dones, 1);
        if (chk_cycles) check("no_bubbles", c, n);
        tick();
        check("done_one_cycle", {31'd0, a_done}, 32'd0);
    endtask

    initial begin
        a_S[0] = 8'd0;  a_S[1] = 8'd5; a_S[2] = 8'd10; a_S[3] = 8'd20;
        b_S[0] = 12'hABC; b_S[1] = 12'h123; b_S[2] = 12'h456; b_S[3] = 12'h789;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_done", {31'd0, a_done}, 32'd0);
        check("rst_data", {24'd0, a_data}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: full-length stream, ready always high
        exp_q = '{8'h04, 8'h00, 8'h05, 8'h0A, 8'h14, 8'h00, 8'h00, 8'h00};
        capture_a(8'd4);
        check("hdr_visible", {31'd0, a_valid}, 32'd1);
        check("hdr_data", {24'd0, a_data}, 32'h04);
        run_a(5, 0, 1'b1);

        // 2: same vector with back-pressure
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        capture_a(8'd4);
        run_a(5, 9, 1'b0);

        // 3a: zero length -> header only
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        capture_a(8'd0);
        run_a(1, 0, 1'b1);

        // 3b: over-long length clipped to N
        exp_q = '{8'h04, 8'h00, 8'h05, 8'h0A, 8'h14, 8'h00, 8'h00, 8'h00};
        capture_a(8'd9);
        run_a(5, 0, 1'b1);

        // 4: 12-bit elements, two bytes each, top nibble padded
        b_len = 8'd1;
        b_cap = 1'b1;
        tick();
        b_cap = 1'b0;
        check("b_hdr", {24'd0, b_data}, 32'h01);
        check("b_hdr_valid", {31'd0, b_valid}, 32'd1);
        tick();
        check("b_lo", {24'd0, b_data}, 32'hBC);
        tick();
        check("b_hi", {24'd0, b_data}, 32'h0A);
        check("b_hi_valid", {31'd0, b_valid}, 32'd1);
        tick();
        check("b_done", {31'd0, b_done}, 32'd1);
        check("b_idle_valid", {31'd0, b_valid}, 32'd0);
        tick();
        check("b_done_clear", {31'd0, b_done}, 32'd0);

        // 5: S changes and capture held after acceptance; the capture still
        //    asserted on the done cycle starts a new transfer with new data
        exp_q = '{8'h04, 8'h00, 8'h05, 8'h0A, 8'h14, 8'h00, 8'h00, 8'h00};
        capture_a(8'd4);
        for (int i = 0; i < 4; i++) a_S[i] = 8'hFF;
        a_cap = 1'b1;
        run_a(5, 0, 1'b1);
        a_cap = 1'b0;
        check("recap_valid", {31'd0, a_valid}, 32'd1);
        check("recap_busy", {31'd0, a_busy}, 32'd1);
        check("recap_hdr", {24'd0, a_data}, 32'h04);
        exp_q = '{8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        run_a(5, 0, 1'b1);

        // 6: reset during DATA aborts without done
        a_S[0] = 8'd0; a_S[1] = 8'd5; a_S[2] = 8'd10; a_S[3] = 8'd20;
        a_ready = 1'b1;
        capture_a(8'd4);
        tick();
        tick();
        check("pre_rst_data", {24'd0, a_data}, 32'h05);
        rst_n = 1'b0;
        tick();
        check("abort_valid", {31'd0, a_valid}, 32'd0);
        check("abort_busy", {31'd0, a_busy}, 32'd0);
        check("abort_done", {31'd0, a_done}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("abort_no_done", {31'd0, a_done}, 32'd0);
        exp_q = '{8'h04, 8'h00, 8'h05, 8'h0A, 8'h14, 8'h00, 8'h00, 8'h00};
        capture_a(8'd4);
        run_a(5, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
